// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: front end of the single-cycle MIPS core.
// Owns the PC, fetches instruction words over a req/valid handshake, holds
// the fetched word for the controller, registers the controller's BEQ state
// (NORMAL/BEQ_IN/EQUAL) and redirects the PC on a taken BEQ.
//
// Optional feature macro: FETCH_HALT_EN
//   When defined, opcode 6'h3F in F_EXEC parks the unit in a terminal F_HALT
//   state and the extra output 'halted' is present. Only reset leaves F_HALT.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   next_state  in   [1:0]  controller's next BEQ state
//   imem_rdata  in   [31:0] instruction memory read data
//   imem_valid  in   read data valid (sampled only in F_REQ)
//   imem_req    out  instruction read request
//   imem_addr   out  [31:0] word-aligned read address (= pc)
//   instn       out  [31:0] held instruction word
//   inst_valid  out  one-cycle commit strobe
//   state       out  [1:0]  registered BEQ state
//   pc          out  [31:0] current PC
//   halted      out  terminal halt flag (FETCH_HALT_EN only)
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [5:0]  BEQ_OPCODE = 6'h04
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  next_state,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instn,
  output logic        inst_valid,
  output logic [1:0]  state,
  output logic [31:0] pc
`ifdef FETCH_HALT_EN
  ,
  output logic        halted
`endif
);

  localparam int unsigned W_WORD = 32;
  localparam int unsigned W_BST  = 2;
  localparam int unsigned W_OPC  = 6;
  localparam int unsigned W_IMM  = 16;
`ifdef FETCH_HALT_EN
  localparam int unsigned W_FSM  = 3;
  localparam logic [W_OPC-1:0] HALT_OPCODE = 6'h3F;
`else
  localparam int unsigned W_FSM  = 2;
`endif

  localparam logic [W_BST-1:0] BST_NORMAL = 2'b00;
  localparam logic [W_BST-1:0] BST_BEQ_IN = 2'b01;
  localparam logic [W_BST-1:0] BST_EQUAL  = 2'b10;

  typedef enum logic [W_FSM-1:0] {
    F_IDLE   = W_FSM'(0),
    F_REQ    = W_FSM'(1),
    F_EXEC   = W_FSM'(2),
    F_BRANCH = W_FSM'(3)
`ifdef FETCH_HALT_EN
    ,
    F_HALT   = W_FSM'(4)
`endif
  } fstate_e;

  fstate_e fstate, fnext;

  logic [W_BST-1:0]  ns_eff;
  logic              is_beq;
  logic [W_WORD-1:0] pc_plus4;
  logic [W_WORD-1:0] branch_off;
  logic [W_WORD-1:0] branch_target;

  logic [W_WORD-1:0] pc_d;
  logic [W_WORD-1:0] instn_d;
  logic [W_BST-1:0]  state_d;
  logic              req_d;
  logic              valid_d;
`ifdef FETCH_HALT_EN
  logic              halt_op;
  logic              halted_d;
`endif

  // Encoding 2'b11 is not a legal controller state; fold it onto NORMAL.
  assign ns_eff = (next_state == 2'b11) ? BST_NORMAL : next_state;

  // Branch target arithmetic; all sums wrap modulo 2^32.
  assign is_beq        = (instn[W_WORD-1 -: W_OPC] == BEQ_OPCODE);
  assign pc_plus4      = pc + W_WORD'(4);
  assign branch_off    = {{(W_WORD-W_IMM-2){instn[W_IMM-1]}}, instn[W_IMM-1:0], 2'b00};
  assign branch_target = pc_plus4 + branch_off;
`ifdef FETCH_HALT_EN
  assign halt_op       = (instn[W_WORD-1 -: W_OPC] == HALT_OPCODE);
`endif

  assign imem_addr = pc;

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fstate <= F_IDLE;
    else        fstate <= fnext;
  end

  // Fetch FSM next-state logic.
  always_comb begin
    fnext = fstate;
    case (fstate)
      F_IDLE: fnext = F_REQ;
      F_REQ: begin
        if (imem_valid) fnext = F_EXEC;
      end
      F_EXEC: begin
`ifdef FETCH_HALT_EN
        if (halt_op)                       fnext = F_HALT;
        else
`endif
        if (ns_eff == BST_BEQ_IN)          fnext = F_BRANCH;
        else                               fnext = F_REQ;
      end
      F_BRANCH: begin
        // Stay one more cycle only for the EQUAL beat of a resolving branch.
        if ((state == BST_BEQ_IN) && (ns_eff == BST_EQUAL)) fnext = F_BRANCH;
        else                                                fnext = F_REQ;
      end
`ifdef FETCH_HALT_EN
      F_HALT: fnext = F_HALT;
`endif
      default: fnext = F_IDLE;
    endcase
  end

  // Output and datapath next values; strobes are computed from the next state
  // so they come out of flops aligned with the state they describe.
  always_comb begin
    pc_d    = pc;
    instn_d = instn;
    state_d = state;
    req_d   = (fnext == F_REQ);
    valid_d = (fnext == F_EXEC);
`ifdef FETCH_HALT_EN
    halted_d = (fnext == F_HALT);
`endif
    case (fstate)
      F_REQ: begin
        if (imem_valid) instn_d = imem_rdata;
      end
      F_EXEC: begin
        state_d = ns_eff;
        if (fnext == F_REQ) pc_d = pc_plus4;
      end
      F_BRANCH: begin
        state_d = ns_eff;
        // A non-BEQ opcode reported as EQUAL falls through to pc+4.
        if (state == BST_BEQ_IN) begin
          pc_d = ((ns_eff == BST_EQUAL) && is_beq) ? branch_target : pc_plus4;
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      instn      <= '0;
      state      <= BST_NORMAL;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
`ifdef FETCH_HALT_EN
      halted     <= 1'b0;
`endif
    end else begin
      pc         <= pc_d;
      instn      <= instn_d;
      state      <= state_d;
      imem_req   <= req_d;
      inst_valid <= valid_d;
`ifdef FETCH_HALT_EN
      halted     <= halted_d;
`endif
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed testbench for inst_fetch_unit: walks a small program through the
// fetch unit, driving imem and controller inputs by hand on the falling edge
// and checking outputs against hand-computed values.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  next_state = 2'b00;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_valid = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instn;
  logic        inst_valid;
  logic [1:0]  state;
  logic [31:0] pc;

  // Second instance starting at the top of the address space.
  logic [1:0]  w_next_state = 2'b00;
  logic [31:0] w_imem_rdata = 32'h0000_0007;
  logic        w_imem_valid = 1'b1;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_instn;
  logic        w_inst_valid;
  logic [1:0]  w_state;
  logic [31:0] w_pc;
`ifdef FETCH_HALT_EN
  logic        halted;
  logic        w_halted;
`endif

  int n_cmp = 0;
  int n_err = 0;

  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .next_state(next_state),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .imem_req(imem_req), .imem_addr(imem_addr), .instn(instn),
    .inst_valid(inst_valid), .state(state), .pc(pc)
`ifdef FETCH_HALT_EN
    , .halted(halted)
`endif
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .next_state(w_next_state),
    .imem_rdata(w_imem_rdata), .imem_valid(w_imem_valid),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .instn(w_instn),
    .inst_valid(w_inst_valid), .state(w_state), .pc(w_pc)
`ifdef FETCH_HALT_EN
    , .halted(w_halted)
`endif
  );

  always #5 clk = ~clk;

  // Program image.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h00:  rom = 32'h0000_0001;
      32'h04:  rom = 32'h0000_0002;
      32'h08:  rom = 32'h0000_0003;
      32'h0C:  rom = 32'h0000_000C;
      32'h10:  rom = 32'h1022_0003;  // beq, +3 words
      32'h14:  rom = 32'h0000_1234;  // opcode 0 with nonzero imm
      32'h18:  rom = 32'hFC00_0000;  // opcode 3F
      32'h1C:  rom = 32'h0000_0005;
      32'h20:  rom = 32'h1022_FFFE;  // beq, -2 words
      32'h24:  rom = 32'h1022_0006;  // beq, +6 words
      32'h40:  rom = 32'h0000_0040;
      default: rom = 32'h0000_0000;
    endcase
  endfunction

  // Serve one fetch: wait for imem_req, assert imem_valid after 'waits' stall
  // cycles, and return at the falling edge of the F_EXEC cycle.
  task automatic do_fetch(input int waits, input logic [1:0] ns,
                          output logic [31:0] addr, output int cycles,
                          output logic stable, output logic held, output logic ok);
    logic [31:0] instn0;
    int cnt;
    ok = 1'b1; stable = 1'b1; held = 1'b1; cycles = 0; addr = 32'hx;
    for (int i = 0; i < 50 && imem_req !== 1'b1; i++) @(negedge clk);
    if (imem_req !== 1'b1) begin ok = 1'b0; return; end
    addr = imem_addr;
    instn0 = instn;
    cnt = 0;
    while (imem_req === 1'b1 && cnt < 50) begin
      if (imem_addr !== addr) stable = 1'b0;
      if (instn !== instn0) held = 1'b0;
      next_state = ns;
      if (cnt == waits) begin imem_valid = 1'b1; imem_rdata = rom(imem_addr); end
      else begin imem_valid = 1'b0; imem_rdata = 32'hDEAD_BEEF; end
      cnt++;
      @(negedge clk);
    end
    imem_valid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    cycles = cnt;
    if (cnt >= 50) ok = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pc, instn, state, imem_req, inst_valid} !== {32'h0, 32'h0, 2'b00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: got pc=%h instn=%h state=%b req=%b iv=%b expected 0/0/00/0/0",
               pc, instn, state, imem_req, inst_valid);
    end
    n_cmp++;
    if (w_pc !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL reset_pc_param: got %h expected fffffffc", w_pc);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    n_cmp++;
    if ({w_imem_req, w_imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_err++; $display("FAIL wrap_first_req: got req=%b addr=%h expected 1 fffffffc", w_imem_req, w_imem_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({w_inst_valid, w_instn} !== {1'b1, 32'h0000_0007}) begin
      n_err++; $display("FAIL wrap_exec: got iv=%b instn=%h expected 1 00000007", w_inst_valid, w_instn);
    end
    @(negedge clk);
    n_cmp++;
    if ({w_imem_req, w_imem_addr} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL wrap_next_addr: got req=%b addr=%h expected 1 00000000", w_imem_req, w_imem_addr);
    end
  endtask

  task automatic test_sequence();
    logic [31:0] a; int rc; logic st, hd, ok;
    for (int k = 0; k < 2; k++) begin
      do_fetch(0, 2'b00, a, rc, st, hd, ok);
      n_cmp++;
      if ({ok, a, rc[7:0], inst_valid, instn, state, imem_req} !==
          {1'b1, 32'(k*4), 8'd1, 1'b1, rom(32'(k*4)), 2'b00, 1'b0}) begin
        n_err++;
        $display("FAIL seq_fetch%0d: got ok=%b addr=%h reqcyc=%0d iv=%b instn=%h state=%b req=%b expected addr=%h reqcyc=1 iv=1 instn=%h state=00",
                 k, ok, a, rc, inst_valid, instn, state, imem_req, 32'(k*4), rom(32'(k*4)));
      end
      @(negedge clk);
      n_cmp++;
      if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'(k*4+4)}) begin
        n_err++;
        $display("FAIL seq_next%0d: got iv=%b req=%b addr=%h expected 0 1 %h",
                 k, inst_valid, imem_req, imem_addr, 32'(k*4+4));
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] a; int rc; logic st, hd, ok;
    do_fetch(2, 2'b00, a, rc, st, hd, ok);
    n_cmp++;
    if ({ok, a, rc[7:0], st, hd} !== {1'b1, 32'h8, 8'd3, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL wait_req: got ok=%b addr=%h reqcyc=%0d stable=%b held=%b expected addr=8 reqcyc=3 stable=1 held=1",
               ok, a, rc, st, hd);
    end
    n_cmp++;
    if ({inst_valid, instn} !== {1'b1, 32'h0000_0003}) begin
      n_err++; $display("FAIL wait_capture: got iv=%b instn=%h expected 1 00000003", inst_valid, instn);
    end
    do_fetch(0, 2'b00, a, rc, st, hd, ok);
    n_cmp++;
    if ({ok, a, instn} !== {1'b1, 32'hC, 32'h0000_000C}) begin
      n_err++; $display("FAIL fetch_0c: got ok=%b addr=%h instn=%h expected 0000000c 0000000c", ok, a, instn);
    end
  endtask

  task automatic test_beq_taken(input logic [31:0] exp_pc, input logic [31:0] exp_tgt);
    logic [31:0] a; int rc; logic st, hd, ok;
    do_fetch(0, 2'b01, a, rc, st, hd, ok);
    n_cmp++;
    if ({ok, a, inst_valid, instn} !== {1'b1, exp_pc, 1'b1, rom(exp_pc)}) begin
      n_err++; $display("FAIL taken_fetch_%h: got ok=%b addr=%h iv=%b instn=%h expected %h 1 %h",
                        exp_pc, ok, a, inst_valid, instn, exp_pc, rom(exp_pc));
    end
    @(negedge clk);
    n_cmp++;
    if ({state, inst_valid, imem_req, pc} !== {2'b01, 1'b0, 1'b0, exp_pc}) begin
      n_err++; $display("FAIL taken_beq_in_%h: got state=%b iv=%b req=%b pc=%h expected 01 0 0 %h",
                        exp_pc, state, inst_valid, imem_req, pc, exp_pc);
    end
    next_state = 2'b10; imem_valid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    n_cmp++;
    if ({state, imem_req, pc, instn} !== {2'b10, 1'b0, exp_tgt, rom(exp_pc)}) begin
      n_err++; $display("FAIL taken_equal_%h: got state=%b req=%b pc=%h instn=%h expected 10 0 %h %h",
                        exp_pc, state, imem_req, pc, instn, exp_tgt, rom(exp_pc));
    end
    next_state = 2'b00; imem_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({state, imem_req, imem_addr} !== {2'b00, 1'b1, exp_tgt}) begin
      n_err++; $display("FAIL taken_target_%h: got state=%b req=%b addr=%h expected 00 1 %h",
                        exp_pc, state, imem_req, imem_addr, exp_tgt);
    end
  endtask

  task automatic test_beq_not_taken(input logic [31:0] exp_pc);
    logic [31:0] a; int rc; logic st, hd, ok;
    do_fetch(0, 2'b01, a, rc, st, hd, ok);
    n_cmp++;
    if ({ok, a, instn} !== {1'b1, exp_pc, rom(exp_pc)}) begin
      n_err++; $display("FAIL nt_fetch_%h: got ok=%b addr=%h instn=%h expected %h %h",
                        exp_pc, ok, a, instn, exp_pc, rom(exp_pc));
    end
    @(negedge clk);
    n_cmp++;
    if ({state, imem_req} !== {2'b01, 1'b0}) begin
      n_err++; $display("FAIL nt_beq_in_%h: got state=%b req=%b expected 01 0", exp_pc, state, imem_req);
    end
    next_state = 2'b00;
    @(negedge clk);
    n_cmp++;
    if ({state, imem_req, imem_addr} !== {2'b00, 1'b1, exp_pc + 32'd4}) begin
      n_err++; $display("FAIL nt_next_%h: got state=%b req=%b addr=%h expected 00 1 %h",
                        exp_pc, state, imem_req, imem_addr, exp_pc + 32'd4);
    end
  endtask

  task automatic test_ns_11();
    logic [31:0] a; int rc; logic st, hd, ok;
    do_fetch(0, 2'b11, a, rc, st, hd, ok);
    @(negedge clk);
    n_cmp++;
    if ({ok, a, state, imem_req, imem_addr} !== {1'b1, 32'h1C, 2'b00, 1'b1, 32'h20}) begin
      n_err++; $display("FAIL ns11_as_normal: got ok=%b addr=%h state=%b req=%b next=%h expected 1 0000001c 00 1 00000020",
                        ok, a, state, imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a; int rc; logic st, hd, ok;
    imem_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin
      n_err++; $display("FAIL mid_wait: got req=%b addr=%h expected 1 00000040", imem_req, imem_addr);
    end
    #2 rst_n = 1'b0; imem_valid = 1'b1; imem_rdata = 32'hBADC_0FFE;
    #1;
    n_cmp++;
    if ({imem_req, pc, state, instn} !== {1'b0, 32'h0, 2'b00, 32'h0}) begin
      n_err++; $display("FAIL mid_async_reset: got req=%b pc=%h state=%b instn=%h expected 0 0 00 0",
                        imem_req, pc, state, instn);
    end
    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if ({imem_req, instn} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL mid_stray_valid: got req=%b instn=%h expected 0 0", imem_req, instn);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({imem_req, imem_addr, instn} !== {1'b1, 32'h0, 32'h0}) begin
      n_err++; $display("FAIL mid_restart: got req=%b addr=%h instn=%h expected 1 0 0", imem_req, imem_addr, instn);
    end
    for (int k = 0; k < 4; k++) begin
      do_fetch(0, 2'b00, a, rc, st, hd, ok);
      n_cmp++;
      if ({ok, a, instn} !== {1'b1, 32'(k*4), rom(32'(k*4))}) begin
        n_err++; $display("FAIL refetch%0d: got ok=%b addr=%h instn=%h expected %h %h",
                          k, ok, a, instn, 32'(k*4), rom(32'(k*4)));
      end
    end
  endtask

  task automatic test_equal_non_beq();
    logic [31:0] a; int rc; logic st, hd, ok;
    do_fetch(0, 2'b01, a, rc, st, hd, ok);
    @(negedge clk);
    n_cmp++;
    if ({ok, a, state} !== {1'b1, 32'h14, 2'b01}) begin
      n_err++; $display("FAIL nonbeq_fetch: got ok=%b addr=%h state=%b expected 1 00000014 01", ok, a, state);
    end
    next_state = 2'b10;
    @(negedge clk);
    n_cmp++;
    if ({state, imem_req, pc} !== {2'b10, 1'b0, 32'h18}) begin
      n_err++; $display("FAIL nonbeq_equal_pc: got state=%b req=%b pc=%h expected 10 0 00000018", state, imem_req, pc);
    end
    next_state = 2'b00;
    @(negedge clk);
    n_cmp++;
    if ({state, imem_req, imem_addr} !== {2'b00, 1'b1, 32'h18}) begin
      n_err++; $display("FAIL nonbeq_next: got state=%b req=%b addr=%h expected 00 1 00000018", state, imem_req, imem_addr);
    end
  endtask

  task automatic test_opcode_3f();
    logic [31:0] a; int rc; logic st, hd, ok;
    do_fetch(0, 2'b00, a, rc, st, hd, ok);
    n_cmp++;
    if ({ok, a, inst_valid, instn} !== {1'b1, 32'h18, 1'b1, 32'hFC00_0000}) begin
      n_err++; $display("FAIL op3f_fetch: got ok=%b addr=%h iv=%b instn=%h expected 1 00000018 1 fc000000",
                        ok, a, inst_valid, instn);
    end
`ifdef FETCH_HALT_EN
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({halted, imem_req, inst_valid, pc} !== {1'b1, 1'b0, 1'b0, 32'h18}) begin
      n_err++; $display("FAIL op3f_halt: got halted=%b req=%b iv=%b pc=%h expected 1 0 0 00000018",
                        halted, imem_req, inst_valid, pc);
    end
`else
    @(negedge clk);
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h1C}) begin
      n_err++; $display("FAIL op3f_next: got req=%b addr=%h expected 1 0000001c", imem_req, imem_addr);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_sequence();
    test_wait_states();
    test_beq_taken(32'h10, 32'h20);
    test_beq_taken(32'h20, 32'h1C);
    test_ns_11();
    test_beq_not_taken(32'h20);
    test_beq_taken(32'h24, 32'h40);
    test_reset_mid();
    test_beq_not_taken(32'h10);
    test_equal_non_beq();
    test_opcode_3f();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
